// File: rtl/hazard_forward_unit_pkg.sv
// Shared types for the hazard/forwarding unit: forward-select encodings,
// the shadow-pipeline entry and small helpers used by the top and hazard_match.
package hazard_forward_unit_pkg;

  localparam int NUM_STAGES = 3;
  localparam int STAGE_EX   = 0;
  localparam int STAGE_MEM  = 1;
  localparam int STAGE_WB   = 2;

  typedef enum logic [1:0] {
    FWD_REGFILE = 2'd0,
    FWD_EXMEM   = 2'd1,
    FWD_MEMWB   = 2'd2
  } fwdSel_e;

  typedef struct packed {
    logic       valid;
    logic       writeEn;
    logic [4:0] dst;
    logic       isLoad;
  } shadowEntry_t;

  localparam shadowEntry_t EMPTY_ENTRY = '{valid: 1'b0, writeEn: 1'b0, dst: 5'd0, isLoad: 1'b0};

  // r0 is hard-wired to zero, so an entry targeting it never produces a value.
  function automatic logic isWriter(input logic valid, input logic writeEn, input logic [4:0] dst);
    return valid && writeEn && (dst != 5'd0);
  endfunction

  function automatic fwdSel_e stageFwd(input int stage);
    case (stage)
      STAGE_EX:  return FWD_EXMEM;
      STAGE_MEM: return FWD_MEMWB;
      STAGE_WB:  return FWD_REGFILE;
      default:   return FWD_REGFILE;
    endcase
  endfunction

endpackage

// File: rtl/hazard_forward_unit_match.sv
// hazard_match: compares the two ID source registers against one shadow entry.
module hazard_match
  import hazard_forward_unit_pkg::*;
(
  input  logic       entryValid,
  input  logic       entryWriteEn,
  input  logic [4:0] entryDst,
  input  logic [4:0] registerRs,
  input  logic [4:0] registerRt,
  input  logic       useRs,
  input  logic       useRt,
  output logic       matchRs,
  output logic       matchRt
);

  logic writer;

  assign writer  = isWriter(entryValid, entryWriteEn, entryDst);
  assign matchRs = useRs && writer && (entryDst == registerRs);
  assign matchRt = useRt && writer && (entryDst == registerRt);

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand-forwarding unit tracking a shadow EX/MEM/WB pipeline.
// Define HAZARD_FORWARDING_EN for forwarding; otherwise the unit interlocks until WB.
module hazard_forward_unit
  import hazard_forward_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [4:0]  id_registerRs,
  input  logic [4:0]  id_registerRt,
  input  logic        id_useRs,
  input  logic        id_useRt,
  input  logic [4:0]  id_registerWriteAddress,
  input  logic        id_ifWriteRegsFile,
  input  logic        id_memOutOrAluOutWriteBackToRegFile,
  input  logic        flush,
  output logic        id_shouldStall,
  output logic        ex_bubble,
  output logic [1:0]  ex_forwardA,
  output logic [1:0]  ex_forwardB,
  output logic [15:0] stallCount
);

  shadowEntry_t          pipe [NUM_STAGES];
  shadowEntry_t          exNext;
  logic [NUM_STAGES-1:0] matchRs;
  logic [NUM_STAGES-1:0] matchRt;
  logic                  hazard;
  logic                  idUseRs;
  logic                  idUseRt;
  logic [15:0]           stallCountReg;

  // An empty ID slot never reads anything.
  assign idUseRs = id_valid && id_useRs;
  assign idUseRt = id_valid && id_useRt;

  for (genvar g = 0; g < NUM_STAGES; g++) begin : gMatch
    hazard_match uMatch (
      .entryValid   (pipe[g].valid),
      .entryWriteEn (pipe[g].writeEn),
      .entryDst     (pipe[g].dst),
      .registerRs   (id_registerRs),
      .registerRt   (id_registerRt),
      .useRs        (idUseRs),
      .useRt        (idUseRt),
      .matchRs      (matchRs[g]),
      .matchRt      (matchRt[g])
    );
  end

`ifdef HAZARD_FORWARDING_EN
  fwdSel_e    fwdANext;
  fwdSel_e    fwdBNext;
  logic [1:0] fwdAReg;
  logic [1:0] fwdBReg;

  // Walk WB->EX so the youngest producer wins; WB maps to the write-through regfile.
  always_comb begin
    hazard   = 1'b0;
    fwdANext = FWD_REGFILE;
    fwdBNext = FWD_REGFILE;
    for (int s = NUM_STAGES - 1; s >= 0; s--) begin
      if ((s == STAGE_EX) && pipe[s].isLoad) begin
        if (matchRs[s] || matchRt[s]) hazard = 1'b1;
        else                          hazard = hazard;
      end else begin
        if (matchRs[s]) fwdANext = stageFwd(s);
        else            fwdANext = fwdANext;
        if (matchRt[s]) fwdBNext = stageFwd(s);
        else            fwdBNext = fwdBNext;
      end
    end
  end

  // Forward selects for the instruction entering EX; a bubble carries no operands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwdAReg <= 2'd0;
      fwdBReg <= 2'd0;
    end else if (ex_bubble) begin
      fwdAReg <= 2'd0;
      fwdBReg <= 2'd0;
    end else begin
      fwdAReg <= fwdANext;
      fwdBReg <= fwdBNext;
    end
  end

  assign ex_forwardA = fwdAReg;
  assign ex_forwardB = fwdBReg;
`else
  // Interlock: any in-flight producer ahead of WB holds the consumer in ID.
  always_comb begin
    hazard = 1'b0;
    for (int s = 0; s < NUM_STAGES; s++) begin
      if ((s != STAGE_WB) && (matchRs[s] || matchRt[s])) hazard = 1'b1;
      else                                               hazard = hazard;
    end
  end

  assign ex_forwardA = FWD_REGFILE;
  assign ex_forwardB = FWD_REGFILE;
`endif

  assign id_shouldStall = hazard && !flush;
  assign ex_bubble      = id_shouldStall || flush;

  // Entry that EX captures at the next edge.
  always_comb begin
    if (ex_bubble || !id_valid) begin
      exNext = EMPTY_ENTRY;
    end else begin
      exNext = '{valid:   1'b1,
                 writeEn: id_ifWriteRegsFile,
                 dst:     id_registerWriteAddress,
                 isLoad:  id_memOutOrAluOutWriteBackToRegFile};
    end
  end

  // Shadow pipeline advances every cycle regardless of stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_STAGES; s++) pipe[s] <= EMPTY_ENTRY;
    end else begin
      pipe[STAGE_EX]  <= exNext;
      pipe[STAGE_MEM] <= pipe[STAGE_EX];
      pipe[STAGE_WB]  <= pipe[STAGE_MEM];
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stallCountReg <= 16'd0;
    end else if (id_shouldStall && (stallCountReg != 16'hFFFF)) begin
      stallCountReg <= stallCountReg + 16'd1;
    end else begin
      stallCountReg <= stallCountReg;
    end
  end

  assign stallCount = stallCountReg;

endmodule
